// File: rtl/cic_interpolator_pkg.sv
// Shared CIC helpers: ceiling log2 plus the internal-width and output-shift formulas.
// The decimator imports the same package so both directions agree on bit growth.
package cic_interpolator_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Worst-case bit growth through N comb/integrator pairs.
    function automatic int cicWidth(input int dataWidth, input int n, input int r, input int m);
        return dataWidth + n * (clog2(r) + clog2(m));
    endfunction

    // Divides out the polyphase gain (RM)^N / R so that DC gain is unity.
    function automatic int cicShift(input int n, input int r, input int m);
        return (n - 1) * clog2(r) + n * clog2(m);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb section, y = x - x[-M], running at the low rate.
// It advances only when a token arrives; between tokens it holds its output and delay line.
module cic_comb_stage
    import cic_interpolator_pkg::*;
#(
    parameter int W = 12,
    parameter int M = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ena_i,
    input  logic         tok_i,
    input  logic [W-1:0] data_i,
    output logic         tok_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] delay_q [M];
    logic [W-1:0] data_q;
    logic         tok_q;
    logic [W-1:0] diff_d;

    always_comb begin
        diff_d = data_i - delay_q[M-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            tok_q  <= 1'b0;
            for (int i = 0; i < M; i++) begin
                delay_q[i] <= '0;
            end
        end else if (ena_i) begin
            tok_q <= tok_i;
            if (tok_i) begin
                data_q     <= diff_d;
                delay_q[0] <= data_i;
                for (int i = 1; i < M; i++) begin
                    delay_q[i] <= delay_q[i-1];
                end
            end
        end
    end

    assign data_o = data_q;
    assign tok_o  = tok_q;

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: low-rate comb chain, zero-stuffer, full-rate integrators.
// Output is scaled back to unity DC gain and truncated to the input sample width.
module cic_interpolator
    import cic_interpolator_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int R          = 2,
    parameter int N          = 3,
    parameter int M          = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ena_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         valid_o,
    output logic                         underrun_o
);

    localparam int W     = cicWidth(DATA_WIDTH, N, R, M);
    localparam int SHIFT = cicShift(N, R, M);
    localparam int LR    = clog2(R);
    localparam int LAT   = 2 * N + 2;
    localparam int WB    = clog2(LAT + 1);

    logic [LR-1:0]                phase_q, phase_d;
    logic [DATA_WIDTH-1:0]        inReg_q;
    logic                         inTok_q;
    logic                         underrun_q;
    logic [WB-1:0]                warm_q;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic [W-1:0]                 integ_q [N];
    logic [W-1:0]                 integ_d [N];
    logic [W-1:0]                 stuffed_d;
    logic [W-1:0]                 combData [N+1];
    logic                         combTok [N+1];
    logic                         slot;

    assign slot = (phase_q == '0);

    assign combData[0] = {{(W - DATA_WIDTH){inReg_q[DATA_WIDTH-1]}}, inReg_q};
    assign combTok[0]  = inTok_q;

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(
            .W (W),
            .M (M)
        ) u_comb (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .ena_i  (ena_i),
            .tok_i  (combTok[k]),
            .data_i (combData[k]),
            .tok_o  (combTok[k+1]),
            .data_o (combData[k+1])
        );
    end

    // Zero-stuffing happens here: the comb result enters the integrators only on its token cycle.
    always_comb begin
        stuffed_d  = combTok[N] ? combData[N] : '0;
        integ_d[0] = integ_q[0] + stuffed_d;
        for (int j = 1; j < N; j++) begin
            integ_d[j] = integ_q[j] + integ_q[j-1];
        end
        data_d  = DATA_WIDTH'($signed(integ_q[N-1]) >>> SHIFT);
        phase_d = (phase_q == LR'(R - 1)) ? '0 : phase_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q    <= '0;
            inReg_q    <= '0;
            inTok_q    <= 1'b0;
            underrun_q <= 1'b0;
            warm_q     <= '0;
            data_q     <= '0;
            for (int j = 0; j < N; j++) begin
                integ_q[j] <= '0;
            end
        end else if (ena_i) begin
            phase_q <= phase_d;
            inTok_q <= slot;
            if (slot) begin
                inReg_q <= valid_i ? data_i : '0;
                if (!valid_i) begin
                    underrun_q <= 1'b1;
                end
            end
            // Counts enabled cycles until the first slot has reached the output register.
            if (warm_q != WB'(LAT)) begin
                warm_q <= warm_q + 1'b1;
            end
            for (int j = 0; j < N; j++) begin
                integ_q[j] <= integ_d[j];
            end
            data_q <= data_d;
        end
    end

    assign ready_o    = ena_i & ~rst_i & slot;
    assign valid_o    = ena_i & ~rst_i & (warm_q == WB'(LAT));
    assign data_o     = data_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench: an impulse-response convolution model checked every cycle,
// plus literal spot checks of the impulse, step, underrun, enable and reset behaviour.
module tb_cic_interpolator;

    localparam int DW    = 9;
    localparam int R     = 2;
    localparam int N     = 3;
    localparam int M     = 1;
    localparam int LAT   = 2 * N + 2;
    localparam int SHIFT = (N - 1) * $clog2(R) + N * $clog2(M);
    localparam int HMAX  = 64;
    localparam int UMAX  = 4096;

    logic                 clk_i;
    logic                 rst_i;
    logic                 ena_i;
    logic signed [DW-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic signed [DW-1:0] data_o;
    logic                 valid_o;
    logic                 underrun_o;

    int testsRun = 0;
    int failures = 0;

    // Model state: CIC impulse response h, zero-stuffed input history u, enabled-cycle index e.
    int h [HMAX];
    int hLen;
    int u [UMAX];
    int e;
    bit modelUnderrun;
    bit postReset;

    cic_interpolator #(
        .DATA_WIDTH (DW),
        .R          (R),
        .N          (N),
        .M          (M)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ena_i      (ena_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .underrun_o (underrun_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ena, input bit vld, input int data);
        rst_i   = rst;
        ena_i   = ena;
        valid_i = vld;
        data_i  = DW'(data);
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 0);
    endtask

    // h = N-fold convolution of a length-RM boxcar.
    initial begin
        int tmp [HMAX];
        int newLen;
        hLen = 1;
        h[0] = 1;
        for (int s = 0; s < N; s++) begin
            newLen = hLen + R * M - 1;
            for (int i = 0; i < newLen; i++) begin
                tmp[i] = 0;
                for (int j = 0; j < R * M; j++) begin
                    if (i - j >= 0 && i - j < hLen) tmp[i] += h[i - j];
                end
            end
            for (int i = 0; i < newLen; i++) h[i] = tmp[i];
            hLen = newLen;
        end
    end

    function automatic int modelOut(input int idx);
        int n;
        int y;
        int s;
        logic signed [DW-1:0] r;
        n = idx - LAT;
        y = 0;
        if (n >= 0) begin
            for (int k = 0; k < hLen; k++) begin
                if (n - k >= 0) y += h[k] * u[n - k];
            end
        end
        s = y >>> SHIFT;
        r = s[DW-1:0];
        return int'(r);
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            checkOutput("rst_ready", int'(ready_o), 0);
            checkOutput("rst_valid", int'(valid_o), 0);
            e             = 0;
            modelUnderrun = 1'b0;
            postReset     = 1'b1;
        end else begin
            if (postReset) begin
                checkOutput("post_rst_data", int'(data_o), 0);
            end
            postReset = 1'b0;
            checkOutput("underrun_flag", int'(underrun_o), int'(modelUnderrun));
            if (ena_i) begin
                checkOutput("ready", int'(ready_o), int'(e % R == 0));
                checkOutput("valid", int'(valid_o), int'(e >= LAT));
                checkOutput("data", int'(data_o), modelOut(e));
                if (e < UMAX) begin
                    u[e] = (e % R == 0 && valid_i) ? int'(data_i) : 0;
                end
                if (e % R == 0 && !valid_i) modelUnderrun = 1'b1;
                e++;
            end else begin
                checkOutput("ena_low_ready", int'(ready_o), 0);
                checkOutput("ena_low_valid", int'(valid_o), 0);
            end
        end
    end

    initial begin
        int readyCount;
        int expectImp [4];
        int expectNeg [4];
        expectImp = '{63, 191, 191, 63};
        expectNeg = '{-64, -192, -192, -64};
        rst_i   = 1'b1;
        ena_i   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;

        // Positive impulse.
        doReset();
        checkOutput("reset_data", int'(data_o), 0);
        checkOutput("reset_underrun", int'(underrun_o), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 255);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("impulse_pos", int'(data_o), expectImp[i]);
            applyStimulus(1'b0, 1'b1, 1'b1, 0);
        end
        checkOutput("impulse_tail", int'(data_o), 0);

        // Negative impulse.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, -256);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("impulse_neg", int'(data_o), expectNeg[i]);
            applyStimulus(1'b0, 1'b1, 1'b1, 0);
        end

        // Step settles to the input level with no ripple.
        doReset();
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b1, 100);
        checkOutput("step_a", int'(data_o), 100);
        applyStimulus(1'b0, 1'b1, 1'b1, 100);
        checkOutput("step_b", int'(data_o), 100);

        // Alternating full-scale slots.
        doReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, ((i / R) % 2 == 0) ? 255 : -256);
        end

        // Underrun on one slot.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 50);
        checkOutput("underrun_before", int'(underrun_o), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("underrun_rise", int'(underrun_o), 1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b1, 50);
        checkOutput("underrun_sticky", int'(underrun_o), 1);
        doReset();
        checkOutput("underrun_cleared", int'(underrun_o), 0);

        // Enable gap mid-impulse.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 255);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 77);
        checkOutput("ena_hold", int'(data_o), 191);
        applyStimulus(1'b0, 1'b1, 1'b1, 0);
        checkOutput("ena_resume", int'(data_o), 63);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0);

        // Reset mid-response, then a clean restart.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 255);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 0);
        checkOutput("midrst_data", int'(data_o), 0);
        checkOutput("midrst_valid", int'(valid_o), 0);
        checkOutput("midrst_ready", int'(ready_o), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 255);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0);
        checkOutput("restart_first", int'(data_o), 63);

        // Handshake: one ready pulse per R enabled cycles.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 0);
        readyCount = 0;
        for (int i = 1; i <= 20; i++) begin
            if (ready_o) readyCount++;
            applyStimulus(1'b0, 1'b1, 1'b1, (i * 37) % 200 - 100);
        end
        checkOutput("ready_count", readyCount, 20 / R);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
